// File: rtl/logger_pkg.sv
// Shared constants and FSM encoding for the IAGC telemetry logger blocks.
package logger_pkg;

  localparam int AMPLITUDE_DATA_SIZE = 16;
  localparam int UART_DATA_SIZE      = 8;
  localparam int IAGC_STATUS_SIZE    = 4;

  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_RESET = 4'b0000;
  localparam logic [UART_DATA_SIZE-1:0]   SYNC_BYTE         = 8'hA5;

  localparam int FRAME_LEN  = 9;
  localparam int INDEX_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } seqState_t;

endpackage

// File: rtl/log_tick_gen.sv
// Free-running period counter: pulses o_tick on the wrap cycle while enabled,
// holds at zero while disabled.
module log_tick_gen #(
  parameter int TICKS = 300000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_SIZE = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CNT_SIZE-1:0] countReg;
  logic                atWrap;

  assign atWrap = (countReg == CNT_SIZE'(TICKS - 1));
  assign o_tick = i_enable & atWrap;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      countReg <= '0;
    end else if (!i_enable || atWrap) begin
      countReg <= '0;
    end else begin
      countReg <= countReg + CNT_SIZE'(1);
    end
  end

endmodule

// File: rtl/log_frame_sequencer.sv
// Schedules IAGC telemetry frames (sync, 7 payload bytes, XOR checksum) onto
// the shared UART transmitter over a valid/ready byte handshake.
module log_frame_sequencer
  import logger_pkg::*;
#(
  parameter int                     TICKS               = 300000,
  parameter int                     AMPLITUDE_DATA_SIZE = logger_pkg::AMPLITUDE_DATA_SIZE,
  parameter int                     UART_DATA_SIZE      = logger_pkg::UART_DATA_SIZE,
  parameter int                     IAGC_STATUS_SIZE    = logger_pkg::IAGC_STATUS_SIZE,
  parameter logic [UART_DATA_SIZE-1:0] SYNC_BYTE        = logger_pkg::SYNC_BYTE
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic [IAGC_STATUS_SIZE-1:0]    i_iagcStatus,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_referenceAmplitude,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude,
  input  logic [UART_DATA_SIZE-1:0]      i_quotient,
  input  logic [UART_DATA_SIZE-1:0]      i_fractional,
  input  logic                           i_onPhase,
  input  logic                           i_wdValid,
  input  logic                           i_txReady,
  output logic                           o_txValid,
  output logic [UART_DATA_SIZE-1:0]      o_txData,
  output logic                           o_busy,
  output logic [7:0]                     o_overrunCount
);

  logic tick;

  log_tick_gen #(
    .TICKS (TICKS)
  ) tickGen (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  seqState_t                       stateReg, stateNext;
  logic [INDEX_SIZE-1:0]           indexReg, indexNext;
  logic                            pendingReg, pendingNext;
  logic [7:0]                      overrunReg, overrunNext;
  logic [IAGC_STATUS_SIZE-1:0]     statusReg;
  logic                            loadSnap;

  logic [AMPLITUDE_DATA_SIZE-1:0]  snapRefReg, snapErrReg;
  logic [UART_DATA_SIZE-1:0]       snapQuotReg, snapFracReg;
  logic [IAGC_STATUS_SIZE-1:0]     snapStatusReg;
  logic                            snapWdReg, snapOnReg;

  logic                            statusEvt, trigger;
  logic [UART_DATA_SIZE-1:0]       statusByte, checksum, frameByte;

  assign statusEvt = (i_iagcStatus != statusReg) && (i_iagcStatus != IAGC_STATUS_RESET);
  assign trigger   = i_enable && (tick || statusEvt) && (i_iagcStatus != IAGC_STATUS_RESET);

  // Everything a frame carries is derived from the snapshot, never from live inputs.
  assign statusByte = {snapStatusReg, 2'b00, snapWdReg, snapOnReg};
  assign checksum   = snapRefReg[7:0] ^ snapRefReg[15:8] ^ snapErrReg[7:0] ^ snapErrReg[15:8]
                    ^ snapQuotReg ^ snapFracReg ^ statusByte;

  always_comb begin
    frameByte = SYNC_BYTE;
    case (indexReg)
      4'd1:    frameByte = snapRefReg[7:0];
      4'd2:    frameByte = snapRefReg[15:8];
      4'd3:    frameByte = snapErrReg[7:0];
      4'd4:    frameByte = snapErrReg[15:8];
      4'd5:    frameByte = snapQuotReg;
      4'd6:    frameByte = snapFracReg;
      4'd7:    frameByte = statusByte;
      4'd8:    frameByte = checksum;
      default: frameByte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    stateNext   = stateReg;
    indexNext   = indexReg;
    pendingNext = pendingReg;
    overrunNext = overrunReg;
    loadSnap    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (trigger || pendingReg) begin
          stateNext   = SEND;
          indexNext   = '0;
          pendingNext = 1'b0;
          loadSnap    = 1'b1;
        end
      end
      SEND: begin
        if (trigger) begin
          if (!pendingReg) begin
            pendingNext = 1'b1;
          end else if (overrunReg != 8'hFF) begin
            overrunNext = overrunReg + 8'd1;
          end
        end
        if (i_txReady) begin
          if (indexReg == INDEX_SIZE'(FRAME_LEN - 1)) begin
            stateNext = DONE;
          end else begin
            indexNext = indexReg + INDEX_SIZE'(1);
          end
        end
      end
      DONE: begin
        // The pending request is consumed here; a trigger in this same cycle re-arms it.
        pendingNext = trigger;
        if (pendingReg) begin
          stateNext = SEND;
          indexNext = '0;
          loadSnap  = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stateReg      <= IDLE;
      indexReg      <= '0;
      pendingReg    <= 1'b0;
      overrunReg    <= '0;
      statusReg     <= '0;
      snapRefReg    <= '0;
      snapErrReg    <= '0;
      snapQuotReg   <= '0;
      snapFracReg   <= '0;
      snapStatusReg <= '0;
      snapWdReg     <= 1'b0;
      snapOnReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      indexReg   <= indexNext;
      pendingReg <= pendingNext;
      overrunReg <= overrunNext;
      statusReg  <= i_iagcStatus;
      if (loadSnap) begin
        snapRefReg    <= i_referenceAmplitude;
        snapErrReg    <= i_errorAmplitude;
        snapQuotReg   <= i_quotient;
        snapFracReg   <= i_fractional;
        snapStatusReg <= i_iagcStatus;
        snapWdReg     <= i_wdValid;
        snapOnReg     <= i_onPhase;
      end
    end
  end

  assign o_txValid      = (stateReg == SEND);
  assign o_txData       = o_txValid ? frameByte : '0;
  assign o_busy         = (stateReg != IDLE);
  assign o_overrunCount = overrunReg;

endmodule
